sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter and access sequencer for the single asynchronous SRAM shared by the CPU datapath (driven by the instruction sequencer's memory strobes) and a second master (program loader / debug DMA). It grants one requester at a time with round-robin fairness, holds SRAM address, data and strobes stable for a fixed multi-cycle access window, captures read data, and returns a one-cycle completion pulse. It sits between the CPU memory interface (MAR/MDR path) and the SRAM pins, replacing direct Mem_OE/Mem_WE wiring.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- ACCESS_CYCLES, 4, cycles strobes are held per access; legal range 1..15
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  synchronous, active-low reset
- cpu_req / dma_req  in  1  access request, level, held until matching done
- cpu_we / dma_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dma_addr  in  ADDR_W  access address; stable while req high
- cpu_wdata / dma_wdata  in  DATA_W  write data; stable while req high
- cpu_rdata / dma_rdata  out  DATA_W  registered read data, valid from done cycle
- cpu_done / dma_done  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W  registered SRAM address
- sram_wdata  out  DATA_W  registered write data
- sram_rdata  in  DATA_W  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low SRAM strobes, registered
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req high, grant and go to ACCESS; latch sram_addr, sram_wdata, we, grant id. No req: stay.
- Arbitration: single requester wins. Both high: grant port not granted last (last_grant flop). After reset last_grant = DMA, so CPU wins first tie.
- ACCESS: counter counts ACCESS_CYCLES cycles; sram_ce_n = 0 throughout; read: sram_oe_n = 0, sram_we_n = 1; write: sram_we_n = 0, sram_oe_n = 1. On last ACCESS cycle edge, read data captured into granted port's rdata; go to DONE.
- DONE: all strobes high; granted port's done = 1 for exactly this cycle; req inputs ignored; last_grant updated; next state IDLE.
- Write access leaves rdata unchanged. Non-granted port's rdata never changes.
- Requester rule: deassert req by the edge ending its done cycle; req high in following IDLE cycle is a new request.
- req dropped mid-access (protocol violation): access completes, done still pulses.
- Reset (any state): next cycle IDLE, strobes high, done low, rdata both 0, sram_addr/wdata 0, last_grant = DMA, counter 0. No done for aborted access.

## Timing
- Reset values: all *_n strobes 1, done 0, rdata 0, sram_addr 0, sram_wdata 0, busy 0.
- req sampled high in IDLE at cycle t: ACCESS cycles t+1..t+ACCESS_CYCLES, done at t+ACCESS_CYCLES+1, IDLE at t+ACCESS_CYCLES+2.
- Default: 6-cycle request-to-IDLE turnaround; back-to-back throughput one access per ACCESS_CYCLES+2 cycles.
- Strobes, address, wdata all registered: change only at ACCESS entry/exit edges, no glitches.
- Address and wdata stable one full cycle before… and after strobes: not required (same-edge change accepted by SRAM timing at system clock).

## Structure
- Package sram_arb_pkg: state enum (IDLE, ACCESS, DONE), port id enum (PORT_CPU, PORT_DMA), counter width constant.
- Sub-module rr_arb2: 2-input round-robin arbiter, inputs req[1:0], last_grant, output grant id + valid; combinational, reused for future ports.
- Top holds FSM, access counter, latched request, rdata registers.

## Test plan
- Reset: Reset_n = 0 two cycles mid-ACCESS -> next cycle strobes all 1, busy 0, no done, rdata 0.
- CPU read: preload SRAM model 0x0123 = 0xBEEF; cpu_req at t -> ce_n/oe_n low t+1..t+4, cpu_done at t+5, cpu_rdata = 0xBEEF, dma_rdata unchanged.
- DMA write: dma addr 0x00010, data 0x1234 -> we_n low 4 cycles, oe_n high, dma_done t+5; CPU read of 0x00010 then returns 0x1234.
- Tie: both req high from reset, held through repeated accesses -> grant order CPU, DMA, CPU, DMA; each done 6 cycles apart.
- Late release: requester holds req one cycle after done -> second identical access performed, second done pulse observed.
- ACCESS_CYCLES = 1 build: done at t+2, strobes low exactly one cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for the SRAM arbiter; FSM states, port ids, access counter width
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_CPU, PORT_DMA} port_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter; req[0]=cpu req[1]=dma, last_grant in, grant id + valid out
import sram_arb_pkg::*;
module rr_arb2 (
  input  logic [1:0] req,
  input  port_t      last_grant,
  output port_t      grant,
  output logic       valid
);
  always_comb begin
    valid = |req;
    grant = &req ? (last_grant == PORT_CPU ? PORT_DMA : PORT_CPU) : (req[1] ? PORT_DMA : PORT_CPU);
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: grants cpu/dma round-robin, holds registered sram addr/wdata/strobes ACCESS_CYCLES cycles, returns rdata + done pulse; Clk, Reset_n(sync low), cpu_*/dma_* req ports, sram_* pins, busy
import sram_arb_pkg::*;
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);
  state_t           state, state_nx;
  port_t            gid, last_grant, arb_grant;
  logic [CNT_W-1:0] cnt;
  logic             we, arb_valid, last_cyc, sel_dma, we_sel;
  rr_arb2 u_arb (
    .req       ({dma_req, cpu_req}),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .valid     (arb_valid)
  );
  assign sel_dma  = arb_grant == PORT_DMA;
  assign we_sel   = sel_dma ? dma_we : cpu_we;
  assign last_cyc = cnt == CNT_W'(ACCESS_CYCLES - 1);
  assign busy     = state != IDLE;
  always_ff @(posedge Clk)
    state <= !Reset_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (arb_valid ? ACCESS : IDLE) : state == ACCESS ? (last_cyc ? DONE : ACCESS) : IDLE;
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt        <= '0;
      gid        <= PORT_CPU;
      we         <= 1'b0;
      last_grant <= PORT_DMA;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      if (state == IDLE && arb_valid) begin
        gid        <= arb_grant;
        we         <= we_sel;
        sram_addr  <= sel_dma ? dma_addr : cpu_addr;
        sram_wdata <= sel_dma ? dma_wdata : cpu_wdata;
        sram_ce_n  <= 1'b0;
        sram_oe_n  <= we_sel;
        sram_we_n  <= !we_sel;
        cnt        <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
        if (last_cyc) begin
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          cpu_done  <= gid == PORT_CPU;
          dma_done  <= gid == PORT_DMA;
          if (!we && gid == PORT_CPU) cpu_rdata <= sram_rdata;
          if (!we && gid == PORT_DMA) dma_rdata <= sram_rdata;
        end
      end else if (state == DONE) begin
        last_grant <= gid;
      end
    end
  end
endmodule
